// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter.
package flash_arb_pkg;

   localparam int unsigned FL_ADDR_W  = 24;
   localparam int unsigned FL_DATA_W  = 16;
   localparam int unsigned WAIT_CNT_W = 12;

   localparam logic [FL_DATA_W-1:0] TIMEOUT_FILL = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_LD  = 1'b0,
      GNT_AUX = 1'b1
   } grant_e;

   // Everything the arbiter drives, registered as one word
   typedef struct packed {
      logic                 fl_rd;
      logic [FL_ADDR_W-1:0] fl_addr;
      logic [FL_DATA_W-1:0] ld_dout;
      logic [FL_DATA_W-1:0] aux_dout;
      logic                 ld_ready;
      logic                 aux_ready;
      logic                 timeout;
      logic                 busy;
   } arb_out_t;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester, flash and status signals of the flash read arbiter.
interface flash_read_arbiter_if;
   import flash_arb_pkg::*;

   logic                 ld_req;
   logic [FL_ADDR_W-1:0] ld_addr;
   logic                 ld_lock;
   logic [FL_DATA_W-1:0] ld_dout;
   logic                 ld_ready;

   logic                 aux_req;
   logic [FL_ADDR_W-1:0] aux_addr;
   logic [FL_DATA_W-1:0] aux_dout;
   logic                 aux_ready;

   logic                 fl_rd;
   logic [FL_ADDR_W-1:0] fl_addr;
   logic [FL_DATA_W-1:0] fl_dout;
   logic                 fl_valid;

   logic                 busy;
   logic                 timeout;

   // Arbiter side
   modport slave (
      input  ld_req, ld_addr, ld_lock,
      output ld_dout, ld_ready,
      input  aux_req, aux_addr,
      output aux_dout, aux_ready,
      output fl_rd, fl_addr,
      input  fl_dout, fl_valid,
      output busy, timeout
   );

   // Requesters and flash controller side
   modport master (
      output ld_req, ld_addr, ld_lock,
      input  ld_dout, ld_ready,
      output aux_req, aux_addr,
      input  aux_dout, aux_ready,
      input  fl_rd, fl_addr,
      output fl_dout, fl_valid,
      input  busy, timeout
   );

endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one flash read port between the loader and an
// auxiliary requester, with a bounded wait for flash data.
module flash_read_arbiter
   import flash_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2048
) (
   input logic                 clk,
   input logic                 reset,
   flash_read_arbiter_if.slave bus
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e            state_q, state_d;
   grant_e                gnt_q, gnt_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   arb_out_t              out_q, out_d;

   logic                 elig_ld_c;
   logic                 elig_aux_c;
   logic                 pick_ld_c;
   logic                 done_c;
   logic [FL_DATA_W-1:0] rsp_data_c;

   assign elig_ld_c  = bus.ld_req;
   assign elig_aux_c = bus.aux_req & ~bus.ld_lock;

   // On a tie the requester that was not granted last wins
   assign pick_ld_c  = elig_ld_c & (~elig_aux_c | (gnt_q == GNT_AUX));

   // Flash data beats the timeout when both land in the same cycle
   assign done_c     = bus.fl_valid | (cnt_q == WAIT_LAST);
   assign rsp_data_c = bus.fl_valid ? bus.fl_dout : TIMEOUT_FILL;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= GNT_AUX;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      gnt_d             = gnt_q;
      cnt_d             = '0;
      out_d             = out_q;
      out_d.fl_rd       = 1'b0;
      out_d.ld_ready    = 1'b0;
      out_d.aux_ready   = 1'b0;
      out_d.timeout     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (elig_ld_c | elig_aux_c) begin
               gnt_d         = pick_ld_c ? GNT_LD : GNT_AUX;
               out_d.fl_rd   = 1'b1;
               out_d.fl_addr = pick_ld_c ? bus.ld_addr : bus.aux_addr;
               state_d       = WAIT;
            end
         end

         WAIT: begin
            if (done_c) begin
               state_d       = RESP;
               out_d.timeout = ~bus.fl_valid;
               if (gnt_q == GNT_LD) begin
                  out_d.ld_dout  = rsp_data_c;
                  out_d.ld_ready = 1'b1;
               end else begin
                  out_d.aux_dout  = rsp_data_c;
                  out_d.aux_ready = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + WAIT_CNT_W'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      out_d.busy = (state_d != IDLE);
   end

   assign bus.fl_rd     = out_q.fl_rd;
   assign bus.fl_addr   = out_q.fl_addr;
   assign bus.ld_dout   = out_q.ld_dout;
   assign bus.aux_dout  = out_q.aux_dout;
   assign bus.ld_ready  = out_q.ld_ready;
   assign bus.aux_ready = out_q.aux_ready;
   assign bus.timeout   = out_q.timeout;
   assign bus.busy      = out_q.busy;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_flash_read_arbiter;
   import flash_arb_pkg::*;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   flash_read_arbiter_if bus();

   flash_read_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model state
   bit          m_last_aux;
   logic [15:0] m_ld_dout;
   logic [15:0] m_aux_dout;

   function automatic bit model_aux_wins(input bit ldq, input bit auxq, input bit lock);
      return auxq && !lock && (!ldq || !m_last_aux);
   endfunction

   task automatic drive_idle();
      bus.ld_req   = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_lock  = 1'b0;
      bus.aux_req  = 1'b0;
      bus.aux_addr = '0;
      bus.fl_dout  = '0;
      bus.fl_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      reset      = 1'b0;
      m_last_aux = 1'b1;
      m_ld_dout  = '0;
      m_aux_dout = '0;
   endtask

   // Step until fl_rd is seen; n = cycles taken, -1 if never
   task automatic wait_rd(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.fl_rd === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Called at the fl_rd cycle: pulse fl_valid after lat cycles, capture the ready cycle
   task automatic serve(input int lat, input logic [15:0] data, output int rdy_cyc,
                        output logic ldr, output logic auxr, output logic tmo,
                        output logic [15:0] ldd, output logic [15:0] auxd);
      rdy_cyc = -1;
      ldr = 1'b0; auxr = 1'b0; tmo = 1'b0; ldd = '0; auxd = '0;
      for (int c = 0; c < TMO + 8; c++) begin
         if (bus.ld_ready === 1'b1 || bus.aux_ready === 1'b1) begin
            rdy_cyc = c;
            ldr  = bus.ld_ready;
            auxr = bus.aux_ready;
            tmo  = bus.timeout;
            ldd  = bus.ld_dout;
            auxd = bus.aux_dout;
            break;
         end
         bus.fl_valid = (c == lat);
         bus.fl_dout  = (c == lat) ? data : 16'($urandom);
         @(negedge clk);
      end
      bus.fl_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ld_req   = 1'($urandom);
         bus.ld_addr  = 24'($urandom);
         bus.ld_lock  = 1'($urandom);
         bus.aux_req  = 1'($urandom);
         bus.aux_addr = 24'($urandom);
         bus.fl_valid = 1'($urandom);
         bus.fl_dout  = 16'($urandom);
         @(negedge clk);
      end
      checks_total++;
      if (bus.fl_rd !== 1'b0) $display("FAIL reset_fl_rd: got %0b want 0", bus.fl_rd);
      else checks_passed++;
      checks_total++;
      if (bus.fl_addr !== 24'h0) $display("FAIL reset_fl_addr: got %h want 000000", bus.fl_addr);
      else checks_passed++;
      checks_total++;
      if ({bus.ld_dout, bus.aux_dout} !== 32'h0)
         $display("FAIL reset_dout: got %h/%h want 0000/0000", bus.ld_dout, bus.aux_dout);
      else checks_passed++;
      checks_total++;
      if ({bus.ld_ready, bus.aux_ready, bus.timeout, bus.busy} !== 4'b0)
         $display("FAIL reset_flags: got rdy=%b%b tmo=%b busy=%b want all 0",
                  bus.ld_ready, bus.aux_ready, bus.timeout, bus.busy);
      else checks_passed++;
      drive_idle();
      reset      = 1'b0;
      m_last_aux = 1'b1;
      m_ld_dout  = '0;
      m_aux_dout = '0;
      @(negedge clk);
      checks_total++;
      if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %0b want 0", bus.busy);
      else checks_passed++;
   endtask

   task automatic test_single_ld();
      int n;
      do_reset();
      bus.ld_req  = 1'b1;
      bus.ld_addr = 24'h200000;
      wait_rd(n);
      checks_total++;
      if (n != 1) $display("FAIL single_rd_latency: got %0d want 1", n);
      else checks_passed++;
      checks_total++;
      if (bus.fl_addr !== 24'h200000) $display("FAIL single_fl_addr: got %h want 200000", bus.fl_addr);
      else checks_passed++;
      @(negedge clk);
      checks_total++;
      if (bus.fl_rd !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL single_rd_strobe: got fl_rd=%b busy=%b want 0/1", bus.fl_rd, bus.busy);
      else checks_passed++;
      bus.fl_valid = 1'b1;
      bus.fl_dout  = 16'hA55A;
      @(negedge clk);
      bus.fl_valid = 1'b0;
      bus.ld_req   = 1'b0;
      checks_total++;
      if ({bus.ld_ready, bus.aux_ready, bus.timeout} !== 3'b100 || bus.ld_dout !== 16'hA55A)
         $display("FAIL single_resp: got rdy=%b%b tmo=%b dout=%h want 10/0/a55a",
                  bus.ld_ready, bus.aux_ready, bus.timeout, bus.ld_dout);
      else checks_passed++;
      m_last_aux = 1'b0;
      m_ld_dout  = 16'hA55A;
      @(negedge clk);
      checks_total++;
      if (bus.ld_ready !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL single_after: got ld_ready=%b busy=%b want 0/0", bus.ld_ready, bus.busy);
      else checks_passed++;
      // Stray flash pulse while idle must be ignored
      bus.fl_valid = 1'b1;
      bus.fl_dout  = 16'h1234;
      @(negedge clk);
      bus.fl_valid = 1'b0;
      @(negedge clk);
      checks_total++;
      if (bus.ld_dout !== m_ld_dout || {bus.ld_ready, bus.aux_ready, bus.busy, bus.fl_rd} !== 4'b0)
         $display("FAIL idle_valid_ignored: got dout=%h rdy=%b%b busy=%b rd=%b want %h/00/0/0",
                  bus.ld_dout, bus.ld_ready, bus.aux_ready, bus.busy, bus.fl_rd, m_ld_dout);
      else checks_passed++;
   endtask

   task automatic test_back_to_back();
      int n, rc;
      logic ldr, auxr, tmo;
      logic [15:0] ldd, auxd, data;
      logic [23:0] ld_a, aux_a;
      bit exp_aux;
      do_reset();
      ld_a  = 24'($urandom);
      aux_a = ld_a ^ 24'h800001;
      bus.ld_req = 1'b1;  bus.ld_addr  = ld_a;
      bus.aux_req = 1'b1; bus.aux_addr = aux_a;
      for (int g = 0; g < 6; g++) begin
         exp_aux = (g % 2) == 1;
         wait_rd(n);
         checks_total++;
         if (n != (g == 0 ? 1 : 2)) $display("FAIL b2b_gap[%0d]: got %0d want %0d", g, n, g == 0 ? 1 : 2);
         else checks_passed++;
         checks_total++;
         if (bus.fl_addr !== (exp_aux ? aux_a : ld_a))
            $display("FAIL b2b_addr[%0d]: got %h want %h", g, bus.fl_addr, exp_aux ? aux_a : ld_a);
         else checks_passed++;
         data = 16'($urandom);
         serve(1, data, rc, ldr, auxr, tmo, ldd, auxd);
         if (exp_aux) m_aux_dout = data; else m_ld_dout = data;
         m_last_aux = exp_aux;
         checks_total++;
         if (rc != 2 || {ldr, auxr} !== (exp_aux ? 2'b01 : 2'b10) || tmo !== 1'b0 ||
             ldd !== m_ld_dout || auxd !== m_aux_dout)
            $display("FAIL b2b_resp[%0d]: got cyc=%0d rdy=%b%b tmo=%b dout=%h/%h want 2/%b/0/%h/%h",
                     g, rc, ldr, auxr, tmo, ldd, auxd, exp_aux ? 2'b01 : 2'b10, m_ld_dout, m_aux_dout);
         else checks_passed++;
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_lock();
      int n, rc;
      logic ldr, auxr, tmo;
      logic [15:0] ldd, auxd, data;
      logic [23:0] ld_a, aux_a;
      do_reset();
      ld_a  = 24'($urandom);
      aux_a = ~ld_a;
      bus.ld_req  = 1'b1; bus.ld_addr  = ld_a;
      bus.aux_req = 1'b1; bus.aux_addr = aux_a;
      bus.ld_lock = 1'b1;
      for (int g = 0; g < 9; g++) begin
         wait_rd(n);
         checks_total++;
         if (bus.fl_addr !== (g == 8 ? aux_a : ld_a))
            $display("FAIL lock_addr[%0d]: got %h want %h", g, bus.fl_addr, g == 8 ? aux_a : ld_a);
         else checks_passed++;
         data = 16'($urandom);
         serve(int'($urandom_range(0, 3)), data, rc, ldr, auxr, tmo, ldd, auxd);
         checks_total++;
         if ({ldr, auxr} !== (g == 8 ? 2'b01 : 2'b10) || (g == 8 ? auxd : ldd) !== data)
            $display("FAIL lock_resp[%0d]: got rdy=%b%b dout=%h/%h want %b data %h",
                     g, ldr, auxr, ldd, auxd, g == 8 ? 2'b01 : 2'b10, data);
         else checks_passed++;
         if (g == 7) bus.ld_lock = 1'b0;
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int n, rc;
      logic ldr, auxr, tmo;
      logic [15:0] ldd, auxd, data;
      do_reset();
      bus.aux_req  = 1'b1;
      bus.aux_addr = 24'h0ABCDE;
      wait_rd(n);
      checks_total++;
      if (bus.fl_addr !== 24'h0ABCDE) $display("FAIL tmo_addr: got %h want 0abcde", bus.fl_addr);
      else checks_passed++;
      serve(1000, 16'h0000, rc, ldr, auxr, tmo, ldd, auxd);
      checks_total++;
      if (rc != TMO || {ldr, auxr, tmo} !== 3'b011 || auxd !== 16'hFFFF)
         $display("FAIL tmo_resp: got cyc=%0d rdy=%b%b tmo=%b dout=%h want %0d/01/1/ffff",
                  rc, ldr, auxr, tmo, auxd, TMO);
      else checks_passed++;
      // Late flash data across RESP and IDLE is ignored
      bus.aux_req  = 1'b0;
      bus.fl_valid = 1'b1;
      bus.fl_dout  = 16'h5A5A;
      @(negedge clk);
      checks_total++;
      if ({bus.aux_ready, bus.timeout, bus.busy} !== 3'b0 || bus.aux_dout !== 16'hFFFF)
         $display("FAIL tmo_after: got rdy=%b tmo=%b busy=%b dout=%h want 0/0/0/ffff",
                  bus.aux_ready, bus.timeout, bus.busy, bus.aux_dout);
      else checks_passed++;
      bus.fl_valid = 1'b0;
      @(negedge clk);
      checks_total++;
      if (bus.aux_dout !== 16'hFFFF || bus.aux_ready !== 1'b0)
         $display("FAIL tmo_late_valid: got dout=%h rdy=%b want ffff/0", bus.aux_dout, bus.aux_ready);
      else checks_passed++;
      // Flash data on the last wait cycle beats the timeout
      bus.ld_req  = 1'b1;
      bus.ld_addr = 24'h123456;
      wait_rd(n);
      data = 16'($urandom);
      serve(TMO - 1, data, rc, ldr, auxr, tmo, ldd, auxd);
      checks_total++;
      if (rc != TMO || {ldr, auxr, tmo} !== 3'b100 || ldd !== data)
         $display("FAIL tmo_tie: got cyc=%0d rdy=%b%b tmo=%b dout=%h want %0d/10/0/%h",
                  rc, ldr, auxr, tmo, ldd, TMO, data);
      else checks_passed++;
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      int n, rc;
      logic ldr, auxr, tmo;
      logic [15:0] ldd, auxd, data;
      do_reset();
      bus.ld_req  = 1'b1;
      bus.ld_addr = 24'h3000AA;
      wait_rd(n);
      repeat (2) @(negedge clk);
      reset       = 1'b1;
      bus.ld_req  = 1'b0;
      @(negedge clk);
      reset        = 1'b0;
      m_last_aux   = 1'b1;
      m_ld_dout    = '0;
      m_aux_dout   = '0;
      checks_total++;
      if ({bus.busy, bus.fl_rd, bus.ld_ready} !== 3'b0)
         $display("FAIL rstwait_state: got busy=%b rd=%b rdy=%b want 000", bus.busy, bus.fl_rd, bus.ld_ready);
      else checks_passed++;
      bus.fl_valid = 1'b1;
      bus.fl_dout  = 16'hBEEF;
      @(negedge clk);
      bus.fl_valid = 1'b0;
      @(negedge clk);
      checks_total++;
      if ({bus.ld_ready, bus.aux_ready, bus.busy} !== 3'b0 || bus.ld_dout !== 16'h0)
         $display("FAIL rstwait_late: got rdy=%b%b busy=%b dout=%h want 00/0/0000",
                  bus.ld_ready, bus.aux_ready, bus.busy, bus.ld_dout);
      else checks_passed++;
      bus.ld_req  = 1'b1;
      bus.ld_addr = 24'h3000BB;
      wait_rd(n);
      checks_total++;
      if (n != 1 || bus.fl_addr !== 24'h3000BB)
         $display("FAIL rstwait_next_rd: got n=%0d addr=%h want 1/3000bb", n, bus.fl_addr);
      else checks_passed++;
      data = 16'($urandom);
      serve(1, data, rc, ldr, auxr, tmo, ldd, auxd);
      checks_total++;
      if (rc != 2 || {ldr, auxr, tmo} !== 3'b100 || ldd !== data)
         $display("FAIL rstwait_next_resp: got cyc=%0d rdy=%b%b tmo=%b dout=%h want 2/10/0/%h",
                  rc, ldr, auxr, tmo, ldd, data);
      else checks_passed++;
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_random();
      int n, rc, lat, r, exp_rc;
      logic ldr, auxr, tmo;
      logic [15:0] ldd, auxd, data, exp_d;
      logic [23:0] ld_a, aux_a;
      bit ldp, auxp, lock, exp_aux, exp_tmo;
      do_reset();
      ldp = 1'b0; auxp = 1'b0; ld_a = '0; aux_a = '0;
      for (int t = 0; t < 40; t++) begin
         if (!ldp && $urandom_range(0, 2) != 0) begin ldp = 1'b1; ld_a = 24'($urandom); end
         if (!auxp && $urandom_range(0, 2) != 0) begin auxp = 1'b1; aux_a = 24'($urandom); end
         lock = ($urandom_range(0, 3) == 0);
         if (!ldp && !(auxp && !lock)) begin
            if (auxp) lock = 1'b0;
            else begin ldp = 1'b1; ld_a = 24'($urandom); end
         end
         bus.ld_req  = ldp;  bus.ld_addr  = ld_a;
         bus.aux_req = auxp; bus.aux_addr = aux_a;
         bus.ld_lock = lock;
         exp_aux = model_aux_wins(ldp, auxp, lock);
         wait_rd(n);
         checks_total++;
         if (n != (t == 0 ? 1 : 2) || bus.fl_addr !== (exp_aux ? aux_a : ld_a))
            $display("FAIL rand_grant[%0d]: got n=%0d addr=%h want %0d/%h",
                     t, n, bus.fl_addr, t == 0 ? 1 : 2, exp_aux ? aux_a : ld_a);
         else checks_passed++;
         if ($urandom_range(0, 3) == 0) bus.ld_lock = ~bus.ld_lock;
         r   = int'($urandom_range(0, 9));
         lat = (r < 7) ? (r % 4) : int'($urandom_range(4, 20));
         data = 16'($urandom);
         serve(lat, data, rc, ldr, auxr, tmo, ldd, auxd);
         exp_tmo = (lat >= TMO);
         exp_rc  = (exp_tmo ? TMO - 1 : lat) + 1;
         exp_d   = exp_tmo ? 16'hFFFF : data;
         if (exp_aux) begin m_aux_dout = exp_d; auxp = 1'b0; bus.aux_req = 1'b0; end
         else         begin m_ld_dout  = exp_d; ldp  = 1'b0; bus.ld_req  = 1'b0; end
         m_last_aux = exp_aux;
         checks_total++;
         if (rc != exp_rc || {ldr, auxr} !== (exp_aux ? 2'b01 : 2'b10) || tmo !== exp_tmo ||
             ldd !== m_ld_dout || auxd !== m_aux_dout)
            $display("FAIL rand_resp[%0d]: got cyc=%0d rdy=%b%b tmo=%b dout=%h/%h want %0d/%b/%b/%h/%h",
                     t, rc, ldr, auxr, tmo, ldd, auxd, exp_rc, exp_aux ? 2'b01 : 2'b10,
                     exp_tmo, m_ld_dout, m_aux_dout);
         else checks_passed++;
      end
      drive_idle();
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      test_reset();
      test_single_ld();
      test_back_to_back();
      test_lock();
      test_timeout();
      test_reset_in_wait();
      test_random();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
